// File: rtl/brisc_pkg.sv
// Shared types and helpers for the branch target buffer.
//   BTB_ENTRIES  : default table depth
//   BTB_MAX_XLEN : width of the tag/target fields in btb_entry_t; narrower
//                  tags and targets are stored zero-extended
//   sat_cnt_t    : 2-bit saturating confidence counter
//   btb_entry_t  : one table entry (valid, tag, target, cnt)
//   sat_inc/dec  : saturating increment/decrement of a sat_cnt_t
package brisc_pkg;

    localparam int BTB_ENTRIES  = 16;
    localparam int BTB_MAX_XLEN = 32;

    typedef logic [1:0] sat_cnt_t;

    typedef struct packed {
        logic                    valid;
        logic [BTB_MAX_XLEN-1:0] tag;
        logic [BTB_MAX_XLEN-1:0] target;
        sat_cnt_t                cnt;
    } btb_entry_t;

    function automatic sat_cnt_t sat_inc(input sat_cnt_t c);
        return (c == 2'b11) ? c : c + 2'b01;
    endfunction

    function automatic sat_cnt_t sat_dec(input sat_cnt_t c);
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// Next-state logic for a 2-bit saturating confidence counter.
//   cnt_in      : current counter value
//   inc_in      : saturating increment
//   dec_in      : saturating decrement
//   load_in     : load load_val_in (takes priority over inc/dec)
//   load_val_in : value used on load
//   cnt_out     : next counter value
module btb_sat_counter
    import brisc_pkg::*;
(
    input  sat_cnt_t cnt_in,
    input  logic     inc_in,
    input  logic     dec_in,
    input  logic     load_in,
    input  sat_cnt_t load_val_in,
    output sat_cnt_t cnt_out
);

    always_comb begin
        cnt_out = cnt_in;
        if (load_in) begin
            cnt_out = load_val_in;
        end else if (inc_in) begin
            cnt_out = sat_inc(cnt_in);
        end else if (dec_in) begin
            cnt_out = sat_dec(cnt_in);
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer / next-PC predictor.
//   clk, reset                 : clock, synchronous active-high reset
//   lookup_pc_in               : fetch PC, predicted combinationally
//   pred_taken_out             : predicted taken for lookup_pc_in
//   pred_target_out            : predicted next PC
//   update_*_in                : branch resolution from execute
//   flush_in                   : invalidate every entry (drops a same-cycle update)
//   hit_count_out              : saturating count of updates that hit
//   mispredict_count_out       : saturating count of mispredicted updates
module btb_predictor
    import brisc_pkg::*;
#(
    parameter int       XLEN        = 32,
    parameter int       NUM_ENTRIES = BTB_ENTRIES,
    parameter sat_cnt_t CNT_INIT    = 2'b10,
    localparam int      IDX_W       = $clog2(NUM_ENTRIES),
    localparam int      TAG_W       = XLEN - 2 - IDX_W
)
(
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] lookup_pc_in,
    output logic            pred_taken_out,
    output logic [XLEN-1:0] pred_target_out,
    input  logic            update_valid_in,
    input  logic [XLEN-1:0] update_pc_in,
    input  logic            update_taken_in,
    input  logic [XLEN-1:0] update_target_in,
    input  logic            flush_in,
    output logic [31:0]     hit_count_out,
    output logic [31:0]     mispredict_count_out
);

    btb_entry_t btb_q [NUM_ENTRIES];
    btb_entry_t btb_d [NUM_ENTRIES];
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] mispredict_count_q, mispredict_count_d;

    logic [IDX_W-1:0]        lk_idx, up_idx;
    logic [BTB_MAX_XLEN-1:0] lk_tag, up_tag;
    btb_entry_t              lk_entry, up_entry;
    logic                    lk_hit, up_hit, up_pred_taken, up_mispredict, accept;
    logic [XLEN-1:0]         up_pred_target;
    sat_cnt_t                up_cnt_next;

    // Fetch-side lookup; reads only the registered table, so a same-cycle
    // update is never visible here.
    assign lk_idx          = lookup_pc_in[IDX_W+1:2];
    assign lk_tag          = BTB_MAX_XLEN'(lookup_pc_in[XLEN-1:IDX_W+2]);
    assign lk_entry        = btb_q[lk_idx];
    assign lk_hit          = lk_entry.valid && (lk_entry.tag == lk_tag);
    assign pred_taken_out  = lk_hit && lk_entry.cnt[1];
    assign pred_target_out = pred_taken_out ? lk_entry.target[XLEN-1:0]
                                            : lookup_pc_in + XLEN'(4);

    // Update-side prediction, recomputed to score the resolved branch.
    assign accept         = update_valid_in && !flush_in;
    assign up_idx         = update_pc_in[IDX_W+1:2];
    assign up_tag         = BTB_MAX_XLEN'(update_pc_in[XLEN-1:IDX_W+2]);
    assign up_entry       = btb_q[up_idx];
    assign up_hit         = up_entry.valid && (up_entry.tag == up_tag);
    assign up_pred_taken  = up_hit && up_entry.cnt[1];
    assign up_pred_target = up_pred_taken ? up_entry.target[XLEN-1:0]
                                          : update_pc_in + XLEN'(4);
    assign up_mispredict  = (up_pred_taken != update_taken_in) ||
                            (update_taken_in && (up_pred_target != update_target_in));

    btb_sat_counter u_sat_counter (
        .cnt_in      (up_entry.cnt),
        .inc_in      (up_hit && update_taken_in),
        .dec_in      (up_hit && !update_taken_in),
        .load_in     (!up_hit && update_taken_in),
        .load_val_in (CNT_INIT),
        .cnt_out     (up_cnt_next)
    );

    always_comb begin
        btb_d              = btb_q;
        hit_count_d        = hit_count_q;
        mispredict_count_d = mispredict_count_q;
        if (flush_in) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                btb_d[i].valid = 1'b0;
            end
        end else if (accept) begin
            // A miss that was not taken leaves the table alone.
            if (up_hit || update_taken_in) begin
                btb_d[up_idx].cnt = up_cnt_next;
                if (update_taken_in) begin
                    btb_d[up_idx].valid  = 1'b1;
                    btb_d[up_idx].tag    = up_tag;
                    btb_d[up_idx].target = BTB_MAX_XLEN'(update_target_in);
                end
            end
            if (up_hit && (hit_count_q != 32'hFFFF_FFFF)) begin
                hit_count_d = hit_count_q + 32'd1;
            end
            if (up_mispredict && (mispredict_count_q != 32'hFFFF_FFFF)) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // Tags and targets are not reset; they are unreachable while valid is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                btb_q[i].valid <= 1'b0;
                btb_q[i].cnt   <= 2'b00;
            end
            hit_count_q        <= '0;
            mispredict_count_q <= '0;
        end else begin
            btb_q              <= btb_d;
            hit_count_q        <= hit_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign hit_count_out        = hit_count_q;
    assign mispredict_count_out = mispredict_count_q;

endmodule
